// File: rtl/image_pkg.sv
// Shared definitions for the image fetch path: FSM encoding, pixel geometry
// and the image-index wrap helper used by the advance timer.
package image_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int ADDR_W          = 20;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR_R = 3'd1;
  localparam logic [2:0] ST_ADDR_G = 3'd2;
  localparam logic [2:0] ST_ADDR_B = 3'd3;
  localparam logic [2:0] ST_CAP_B  = 3'd4;

  function automatic logic [1:0] next_index(input logic [1:0] idx, input int num);
    return (int'(idx) >= num - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/image_advance_timer.sv
// Pending image index: advanced by a manual request or after a dwell of N frames
// in auto mode. Exposes the index including this cycle's advance.
module image_advance_timer
  import image_pkg::*;
#(
  parameter int p_NUM_IMAGES   = 3,
  parameter int p_DWELL_FRAMES = 300
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_FRAME_START,
  input  logic       i_NEXT,
  input  logic       i_AUTO_EN,
  output logic [1:0] o_PENDING_NEXT
);

  localparam int c_CNT_W = $clog2(p_DWELL_FRAMES) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(p_DWELL_FRAMES - 1);

  logic [c_CNT_W-1:0] r_dwell_cnt;
  logic [1:0]         r_pending;
  logic               w_auto_adv;
  logic               w_advance;

  assign w_auto_adv = i_AUTO_EN && i_FRAME_START && (r_dwell_cnt == c_LAST);
  // A manual request and an auto advance in the same cycle count as one step.
  assign w_advance      = i_NEXT || w_auto_adv;
  assign o_PENDING_NEXT = w_advance ? next_index(r_pending, p_NUM_IMAGES) : r_pending;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_pending   <= 2'd0;
      r_dwell_cnt <= '0;
    end else begin
      r_pending <= o_PENDING_NEXT;
      if (w_advance) begin
        r_dwell_cnt <= '0;
      end else if (i_AUTO_EN && i_FRAME_START) begin
        r_dwell_cnt <= r_dwell_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_fetch_sequencer.sv
// Fetches one RGB pixel as three sequential byte reads from the selected image
// and switches the displayed image only at frame boundaries.
module image_fetch_sequencer
  import image_pkg::*;
#(
  parameter int p_RESOLUTION   = 640 * 480,
  parameter int p_NUM_IMAGES   = 3,
  parameter int p_DWELL_FRAMES = 300
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_FRAME_START,
  input  logic              i_PIXEL_REQ,
  input  logic              i_NEXT,
  input  logic              i_AUTO_EN,
  input  logic [7:0]        i_BYTE_DATA,
  output logic [1:0]        o_IMAGE_SELECT,
  output logic              o_RD_EN,
  output logic [ADDR_W-1:0] o_BYTE_ADDR,
  output logic [23:0]       o_RGB,
  output logic              o_RGB_VALID,
  output logic              o_UNDERRUN
);

  localparam addr_t c_WRAP = addr_t'(p_RESOLUTION * BYTES_PER_PIXEL);
  localparam addr_t c_STEP = addr_t'(BYTES_PER_PIXEL);

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  addr_t      r_base;
  addr_t      w_base_step;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [1:0] w_pending_next;

  image_advance_timer #(
    .p_NUM_IMAGES  (p_NUM_IMAGES),
    .p_DWELL_FRAMES(p_DWELL_FRAMES)
  ) u_advance_timer (
    .i_CLK         (i_CLK),
    .i_RESET       (i_RESET),
    .i_FRAME_START (i_FRAME_START),
    .i_NEXT        (i_NEXT),
    .i_AUTO_EN     (i_AUTO_EN),
    .o_PENDING_NEXT(w_pending_next)
  );

  assign w_base_step = r_base + c_STEP;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (i_FRAME_START && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_PIXEL_REQ) w_state_next = ST_ADDR_R;
        ST_ADDR_R: w_state_next = ST_ADDR_G;
        ST_ADDR_G: w_state_next = ST_ADDR_B;
        ST_ADDR_B: w_state_next = ST_CAP_B;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_RD_EN     = 1'b0;
    o_BYTE_ADDR = '0;
    case (r_state)
      ST_ADDR_R: begin o_RD_EN = 1'b1; o_BYTE_ADDR = r_base;              end
      ST_ADDR_G: begin o_RD_EN = 1'b1; o_BYTE_ADDR = r_base + addr_t'(1); end
      ST_ADDR_B: begin o_RD_EN = 1'b1; o_BYTE_ADDR = r_base + addr_t'(2); end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_state        <= ST_IDLE;
      r_base         <= '0;
      r_red          <= 8'd0;
      r_green        <= 8'd0;
      o_RGB          <= 24'd0;
      o_RGB_VALID    <= 1'b0;
      o_UNDERRUN     <= 1'b0;
      o_IMAGE_SELECT <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      o_RGB_VALID <= 1'b0;
      if (i_PIXEL_REQ && (r_state != ST_IDLE)) o_UNDERRUN <= 1'b1;
      // A frame start aborts any fetch in flight: nothing is captured.
      if (i_FRAME_START) begin
        o_IMAGE_SELECT <= w_pending_next;
        r_base         <= '0;
      end else begin
        case (r_state)
          ST_ADDR_G: r_red   <= i_BYTE_DATA;
          ST_ADDR_B: r_green <= i_BYTE_DATA;
          ST_CAP_B: begin
            o_RGB       <= {r_red, r_green, i_BYTE_DATA};
            o_RGB_VALID <= 1'b1;
            r_base      <= (w_base_step == c_WRAP) ? '0 : w_base_step;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_fetch_sequencer.sv
// Scoreboard bench: the driver feeds a cycle-level reference model that queues
// expected reads and pixels; a negedge monitor pops and compares DUT outputs.
module tb_image_fetch_sequencer;

  localparam int RES   = 4;
  localparam int NIMG  = 3;
  localparam int DWELL = 2;

  logic        i_CLK = 1'b0;
  logic        i_RESET;
  logic        i_FRAME_START;
  logic        i_PIXEL_REQ;
  logic        i_NEXT;
  logic        i_AUTO_EN;
  logic [7:0]  i_BYTE_DATA;
  logic [1:0]  o_IMAGE_SELECT;
  logic        o_RD_EN;
  logic [19:0] o_BYTE_ADDR;
  logic [23:0] o_RGB;
  logic        o_RGB_VALID;
  logic        o_UNDERRUN;

  always #5 i_CLK = ~i_CLK;

  image_fetch_sequencer #(
    .p_RESOLUTION  (RES),
    .p_NUM_IMAGES  (NIMG),
    .p_DWELL_FRAMES(DWELL)
  ) dut (
    .i_CLK         (i_CLK),
    .i_RESET       (i_RESET),
    .i_FRAME_START (i_FRAME_START),
    .i_PIXEL_REQ   (i_PIXEL_REQ),
    .i_NEXT        (i_NEXT),
    .i_AUTO_EN     (i_AUTO_EN),
    .i_BYTE_DATA   (i_BYTE_DATA),
    .o_IMAGE_SELECT(o_IMAGE_SELECT),
    .o_RD_EN       (o_RD_EN),
    .o_BYTE_ADDR   (o_BYTE_ADDR),
    .o_RGB         (o_RGB),
    .o_RGB_VALID   (o_RGB_VALID),
    .o_UNDERRUN    (o_UNDERRUN)
  );

  typedef struct {
    int          cyc;
    logic [23:0] rgb;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  int          rd_sched[int];
  bit          mon_en   = 1'b0;
  bit          auto_lvl = 1'b0;
  logic [7:0]  mem_pending = 8'h00;

  // Reference model state (values as of the end of the last driven cycle).
  int          busy_end;
  int          m_pix;
  int          m_sel;
  int          m_pend;
  int          m_dwell;
  bit          m_und;
  int          chk_sel;
  bit          chk_und;
  logic [23:0] exp_hold;

  function automatic logic [7:0] byte_of(int img, int addr);
    return 8'((addr + 1) * 17) ^ 8'(img * 90);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rd_sched.delete();
    busy_end = -1;
    m_pix    = 0;
    m_sel    = 0;
    m_pend   = 0;
    m_dwell  = 0;
    m_und    = 1'b0;
    chk_sel  = 0;
    chk_und  = 1'b0;
    exp_hold = 24'd0;
  endtask

  // One cycle of the specified behaviour: a pixel fetch occupies the four
  // cycles after its request; a frame start cancels it and restarts at pixel 0.
  task automatic model_cycle(int t, bit fs, bit req, bit nx, bit au);
    bit idle;
    bit inc;
    int a;
    idle = (t > busy_end);
    if (fs && !idle) begin
      for (int k = t + 1; k <= t + 4; k++)
        if (rd_sched.exists(k)) rd_sched.delete(k);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      busy_end = t;
    end
    inc = nx || (au && fs && (m_dwell == DWELL - 1));
    if (nx) m_dwell = 0;
    else if (au && fs) m_dwell = (m_dwell == DWELL - 1) ? 0 : m_dwell + 1;
    if (inc) m_pend = (m_pend + 1) % NIMG;
    if (fs) begin
      m_sel = m_pend;
      m_pix = 0;
    end
    if (req) begin
      if (idle) begin
        a = 3 * m_pix;
        rd_sched[t + 1] = a;
        rd_sched[t + 2] = a + 1;
        rd_sched[t + 3] = a + 2;
        exp_q.push_back('{cyc: t + 5,
                          rgb: {byte_of(m_sel, a), byte_of(m_sel, a + 1), byte_of(m_sel, a + 2)}});
        busy_end = t + 4;
        m_pix    = (m_pix + 1) % RES;
      end else begin
        m_und = 1'b1;
      end
    end
  endtask

  task automatic drive(bit fs, bit req, bit nx);
    i_FRAME_START = fs;
    i_PIXEL_REQ   = req;
    i_NEXT        = nx;
    i_AUTO_EN     = auto_lvl;
    model_cycle(cyc, fs, req, nx, auto_lvl);
    @(posedge i_CLK);
    cyc++;
    chk_sel = m_sel;
    chk_und = m_und;
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    mon_en        = 1'b0;
    i_RESET       = 1'b1;
    i_FRAME_START = 1'b0;
    i_PIXEL_REQ   = 1'b0;
    i_NEXT        = 1'b0;
    i_AUTO_EN     = auto_lvl;
    model_reset();
    #2;
    check("rst_rd_en",     o_RD_EN,        0);
    check("rst_byte_addr", o_BYTE_ADDR,    0);
    check("rst_rgb",       o_RGB,          0);
    check("rst_rgb_valid", o_RGB_VALID,    0);
    check("rst_underrun",  o_UNDERRUN,     0);
    check("rst_select",    o_IMAGE_SELECT, 0);
    @(posedge i_CLK); cyc++;
    @(posedge i_CLK); cyc++;
    #1;
    i_RESET = 1'b0;
    mon_en  = 1'b1;
  endtask

  // Image memory: data for a read appears during the following cycle.
  always @(negedge i_CLK) begin
    i_BYTE_DATA = mem_pending;
    mem_pending = o_RD_EN ? byte_of(int'(o_IMAGE_SELECT), int'(o_BYTE_ADDR)) : 8'($urandom);
  end

  always @(negedge i_CLK) begin
    if (mon_en) begin
      check("image_select", o_IMAGE_SELECT, chk_sel);
      check("underrun", o_UNDERRUN, chk_und);
      if (rd_sched.exists(cyc)) begin
        check("rd_en", o_RD_EN, 1);
        check("byte_addr", o_BYTE_ADDR, rd_sched[cyc]);
      end else begin
        check("rd_en_idle", o_RD_EN, 0);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rgb_valid", o_RGB_VALID, 1);
        exp_hold = e.rgb;
      end else begin
        check("rgb_valid_idle", o_RGB_VALID, 0);
      end
      check("rgb", o_RGB, exp_hold);
    end
  end

  int auto_seq[6] = '{0, 1, 1, 2, 2, 0};

  initial begin
    do_reset();

    // First request right after reset release: bytes 11,22,33 from image 0.
    drive(1'b0, 1'b1, 1'b0);
    idle(6);
    check("first_pixel", o_RGB, 24'h112233);

    // Request while busy is dropped and latches underrun until reset.
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 1'b0);
    idle(6);
    check("underrun_sticky", o_UNDERRUN, 1);
    do_reset();
    check("underrun_cleared", o_UNDERRUN, 0);

    // Address wrap after RES pixels.
    for (int p = 0; p < 5; p++) begin
      drive(1'b0, 1'b1, 1'b0);
      idle(5);
    end

    // Manual advance only takes effect at the frame start.
    drive(1'b0, 1'b0, 1'b1);
    idle(1);
    drive(1'b0, 1'b0, 1'b1);
    idle(3);
    check("select_held", o_IMAGE_SELECT, 0);
    drive(1'b1, 1'b0, 1'b0);
    idle(2);
    check("select_after_two", o_IMAGE_SELECT, 2);
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
    check("select_before_frame", o_IMAGE_SELECT, 2);
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    check("select_wrap", o_IMAGE_SELECT, 0);

    // Timed advance every DWELL frames, then a coincident manual request.
    do_reset();
    auto_lvl = 1'b1;
    for (int f = 0; f < 6; f++) begin
      drive(1'b1, 1'b0, 1'b0);
      idle(1);
      check($sformatf("auto_select_%0d", f), o_IMAGE_SELECT, auto_seq[f]);
      idle(1);
    end
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    check("auto_plus_next", o_IMAGE_SELECT, 1);
    auto_lvl = 1'b0;

    // Frame start during ADDR_G aborts the pixel; next request starts at 0.
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    idle(5);
    drive(1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    idle(6);
    drive(1'b0, 1'b1, 1'b0);
    idle(5);
    drive(1'b1, 1'b1, 1'b0);
    idle(6);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) auto_lvl = ~auto_lvl;
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
    end
    idle(8);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
